// File: rtl/cmac_link_sync_pkg.sv
// Shared types and constants for the multi-port CMAC link bring-up controller.
package cmac_link_sync_pkg;

  typedef enum logic [2:0] {
    LinkIdle      = 3'd0,
    LinkWaitAlign = 3'd1,
    LinkResync    = 3'd2,
    LinkUp        = 3'd3,
    LinkFail      = 3'd4
  } link_state_t;

  localparam int unsigned LINK_DOWN_CNT_W = 16;
  localparam int unsigned SYNC_STAGES     = 2;

endpackage

// File: rtl/cmac_link_sync_if.sv
// CMAC stat/ctl and status bundle; link_down_cnt only exists with CMAC_LINK_SYNC_STATS_EN.
interface cmac_link_sync_if
  import cmac_link_sync_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
);

  logic [NUM_PORTS-1:0] restart;
  logic [NUM_PORTS-1:0] stat_rx_aligned;
  logic [NUM_PORTS-1:0] ctl_rx_enable;
  logic [NUM_PORTS-1:0] ctl_rx_force_resync;
  logic [NUM_PORTS-1:0] ctl_tx_enable;
  logic [NUM_PORTS-1:0] ctl_tx_send_rfi;
  logic [NUM_PORTS-1:0] ctl_tx_send_idle;
  logic [NUM_PORTS-1:0] link_up;
  logic [NUM_PORTS-1:0] busy_led;
  logic [NUM_PORTS-1:0] fail_led;
  logic                 all_links_up;

`ifdef CMAC_LINK_SYNC_STATS_EN
  logic [NUM_PORTS*LINK_DOWN_CNT_W-1:0] link_down_cnt;

  modport master (
    output restart, stat_rx_aligned,
    input  ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable, ctl_tx_send_rfi,
    input  ctl_tx_send_idle, link_up, busy_led, fail_led, all_links_up, link_down_cnt
  );
  modport slave (
    input  restart, stat_rx_aligned,
    output ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable, ctl_tx_send_rfi,
    output ctl_tx_send_idle, link_up, busy_led, fail_led, all_links_up, link_down_cnt
  );
`else
  modport master (
    output restart, stat_rx_aligned,
    input  ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable, ctl_tx_send_rfi,
    input  ctl_tx_send_idle, link_up, busy_led, fail_led, all_links_up
  );
  modport slave (
    input  restart, stat_rx_aligned,
    output ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable, ctl_tx_send_rfi,
    output ctl_tx_send_idle, link_up, busy_led, fail_led, all_links_up
  );
`endif

endinterface

// File: rtl/cmac_link_sync_port.sv
// One CMAC port: aligned synchroniser, bring-up FSM, stability/timeout/retry counters.
// Link-loss counter present only with CMAC_LINK_SYNC_STATS_EN.
module cmac_link_sync_port
  import cmac_link_sync_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned ALIGN_TIMEOUT = 2**20,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic stat_rx_aligned,
  output logic ctl_rx_enable,
  output logic ctl_rx_force_resync,
  output logic ctl_tx_enable,
  output logic ctl_tx_send_rfi,
  output logic ctl_tx_send_idle,
  output logic link_up,
  output logic busy_led,
  output logic fail_led
`ifdef CMAC_LINK_SYNC_STATS_EN
  ,
  output logic [LINK_DOWN_CNT_W-1:0] link_down_cnt
`endif
);

  localparam logic [2:0] StIdle      = LinkIdle;
  localparam logic [2:0] StWaitAlign = LinkWaitAlign;
  localparam logic [2:0] StResync    = LinkResync;
  localparam logic [2:0] StLinkUp    = LinkUp;
  localparam logic [2:0] StFail      = LinkFail;

  localparam int unsigned StabW  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned TmoW   = $clog2(ALIGN_TIMEOUT) + 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES) + 1;

  localparam logic [StabW-1:0]  StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(ALIGN_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   aln_s;
  logic [2:0]             state_q, state_d;
  logic [StabW-1:0]       stab_q, stab_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic rx_en_d, resync_d, tx_en_d, rfi_d, up_d, busy_d, fail_d;

  assign aln_s            = sync_q[SYNC_STAGES-1];
  assign ctl_tx_send_idle = 1'b0;

  // Counters only run while staying in WAIT_ALIGN; every other path clears them.
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    tmo_d   = '0;
    retry_d = retry_q;
    if (restart) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      case (state_q)
        StIdle:      state_d = StWaitAlign;
        StWaitAlign: begin
          if (aln_s && (stab_q == StabLast)) begin
            state_d = StLinkUp;
            retry_d = '0;
          end else if (tmo_q == TmoLast) begin
            if (retry_q == RetryMax) begin
              state_d = StFail;
            end else begin
              state_d = StResync;
              retry_d = retry_q + RetryW'(1);
            end
          end else begin
            stab_d = aln_s ? stab_q + StabW'(1) : '0;
            tmo_d  = tmo_q + TmoW'(1);
          end
        end
        StResync:    state_d = StWaitAlign;
        StLinkUp:    if (!aln_s) state_d = StWaitAlign;
        StFail:      state_d = StFail;
        default:     state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rx_en_d  = 1'b0;
    resync_d = 1'b0;
    tx_en_d  = 1'b0;
    rfi_d    = 1'b0;
    up_d     = 1'b0;
    busy_d   = 1'b0;
    fail_d   = 1'b0;
    case (state_d)
      StWaitAlign: begin rx_en_d = 1'b1; rfi_d = 1'b1; busy_d = 1'b1; end
      StResync:    begin rx_en_d = 1'b1; rfi_d = 1'b1; busy_d = 1'b1; resync_d = 1'b1; end
      StLinkUp:    begin rx_en_d = 1'b1; tx_en_d = 1'b1; up_d = 1'b1; end
      StFail:      fail_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q              <= '0;
      state_q             <= StIdle;
      stab_q              <= '0;
      tmo_q               <= '0;
      retry_q             <= '0;
      ctl_rx_enable       <= 1'b0;
      ctl_rx_force_resync <= 1'b0;
      ctl_tx_enable       <= 1'b0;
      ctl_tx_send_rfi     <= 1'b0;
      link_up             <= 1'b0;
      busy_led            <= 1'b0;
      fail_led            <= 1'b0;
    end else begin
      sync_q              <= {sync_q[SYNC_STAGES-2:0], stat_rx_aligned};
      state_q             <= state_d;
      stab_q              <= stab_d;
      tmo_q               <= tmo_d;
      retry_q             <= retry_d;
      ctl_rx_enable       <= rx_en_d;
      ctl_rx_force_resync <= resync_d;
      ctl_tx_enable       <= tx_en_d;
      ctl_tx_send_rfi     <= rfi_d;
      link_up             <= up_d;
      busy_led            <= busy_d;
      fail_led            <= fail_d;
    end
  end

`ifdef CMAC_LINK_SYNC_STATS_EN
  logic [LINK_DOWN_CNT_W-1:0] ldc_q;

  // Restart routes LINK_UP to IDLE, so it never counts as a link loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldc_q <= '0;
    end else if ((state_q == StLinkUp) && (state_d == StWaitAlign) && (ldc_q != '1)) begin
      ldc_q <= ldc_q + LINK_DOWN_CNT_W'(1);
    end
  end

  assign link_down_cnt = ldc_q;
`endif

endmodule

// File: rtl/cmac_link_sync.sv
// NUM_PORTS independent CMAC bring-up controllers on the monitor clock.
// Optional per-port link-loss counters via CMAC_LINK_SYNC_STATS_EN.
module cmac_link_sync
  import cmac_link_sync_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned ALIGN_TIMEOUT = 2**20,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input logic             gen_mon_clk,
  input logic             sys_reset_n,
  cmac_link_sync_if.slave bus
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    cmac_link_sync_port #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ALIGN_TIMEOUT(ALIGN_TIMEOUT),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_port (
      .clk                (gen_mon_clk),
      .rst_n              (sys_reset_n),
      .restart            (bus.restart[i]),
      .stat_rx_aligned    (bus.stat_rx_aligned[i]),
      .ctl_rx_enable      (bus.ctl_rx_enable[i]),
      .ctl_rx_force_resync(bus.ctl_rx_force_resync[i]),
      .ctl_tx_enable      (bus.ctl_tx_enable[i]),
      .ctl_tx_send_rfi    (bus.ctl_tx_send_rfi[i]),
      .ctl_tx_send_idle   (bus.ctl_tx_send_idle[i]),
      .link_up            (bus.link_up[i]),
      .busy_led           (bus.busy_led[i]),
      .fail_led           (bus.fail_led[i])
`ifdef CMAC_LINK_SYNC_STATS_EN
      ,
      .link_down_cnt      (bus.link_down_cnt[i*LINK_DOWN_CNT_W +: LINK_DOWN_CNT_W])
`endif
    );
  end

  assign bus.all_links_up = &bus.link_up;

endmodule

// File: tb/tb_cmac_link_sync.sv
// Directed bench for cmac_link_sync: bring-up, timeout/resync/FAIL, link loss, restart, reset.
module tb_cmac_link_sync;

  logic gen_mon_clk = 1'b0;
  logic sys_reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_rs0[$];
  int   exp_rs1[$];

  always #5 gen_mon_clk = ~gen_mon_clk;

  cmac_link_sync_if #(.NUM_PORTS(2)) bus ();

  cmac_link_sync #(
    .NUM_PORTS    (2),
    .STABLE_CYCLES(4),
    .ALIGN_TIMEOUT(16),
    .MAX_RETRIES  (2)
  ) dut (
    .gen_mon_clk(gen_mon_clk),
    .sys_reset_n(sys_reset_n),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Advance one clock, sample at the falling edge, retire any resync pulse against its queue.
  task automatic step();
    @(posedge gen_mon_clk);
    cyc++;
    @(negedge gen_mon_clk);
    if (bus.ctl_rx_force_resync[0]) begin
      if (exp_rs0.size() == 0) check("rs0_unexpected", cyc, 0);
      else check("rs0_cycle", cyc, exp_rs0.pop_front());
    end
    if (bus.ctl_rx_force_resync[1]) begin
      if (exp_rs1.size() == 0) check("rs1_unexpected", cyc, 0);
      else check("rs1_cycle", cyc, exp_rs1.pop_front());
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    bus.restart         = 2'b00;
    bus.stat_rx_aligned = 2'b01;
    #12;
    check("rst_rx_en", 32'(bus.ctl_rx_enable), 0);
    check("rst_tx_en", 32'(bus.ctl_tx_enable), 0);
    check("rst_rfi", 32'(bus.ctl_tx_send_rfi), 0);
    check("rst_busy", 32'(bus.busy_led), 0);
    @(negedge gen_mon_clk);
    sys_reset_n = 1'b1;
    exp_rs1.push_back(17);
    exp_rs1.push_back(34);

    // Port0 aligned from the start.
    run_to(1);
    check("p0_rx_en_c1", 32'(bus.ctl_rx_enable[0]), 1);
    check("p0_rfi_c1", 32'(bus.ctl_tx_send_rfi[0]), 1);
    run_to(5);
    check("p0_up_c5", 32'(bus.link_up[0]), 0);
    run_to(6);
    check("p0_up_c6", 32'(bus.link_up[0]), 1);
    check("p0_tx_en_c6", 32'(bus.ctl_tx_enable[0]), 1);
    check("p0_rfi_c6", 32'(bus.ctl_tx_send_rfi[0]), 0);
    check("send_idle", 32'(bus.ctl_tx_send_idle), 0);

    // Port1 never aligned: two resyncs then FAIL.
    run_to(50);
    check("p1_fail_c50", 32'(bus.fail_led[1]), 0);
    run_to(51);
    check("p1_fail_c51", 32'(bus.fail_led[1]), 1);
    check("p1_busy_c51", 32'(bus.busy_led[1]), 0);
    check("p1_rx_en_c51", 32'(bus.ctl_rx_enable[1]), 0);
    check("all_up_c51", 32'(bus.all_links_up), 0);

    // Port0 loses alignment for one cycle.
    bus.stat_rx_aligned[0] = 1'b0;
    step();
    bus.stat_rx_aligned[0] = 1'b1;
    run_to(53);
    check("p0_up_c53", 32'(bus.link_up[0]), 1);
    run_to(54);
    check("p0_up_c54", 32'(bus.link_up[0]), 0);
    check("p0_rfi_c54", 32'(bus.ctl_tx_send_rfi[0]), 1);
    run_to(57);
    check("p0_up_c57", 32'(bus.link_up[0]), 0);
    run_to(58);
    check("p0_up_c58", 32'(bus.link_up[0]), 1);
`ifdef CMAC_LINK_SYNC_STATS_EN
    check("ldc0_one", 32'(bus.link_down_cnt[15:0]), 1);
    check("ldc1_zero", 32'(bus.link_down_cnt[31:16]), 0);
`endif

    // Restart port1 out of FAIL with alignment present.
    bus.restart[1]         = 1'b1;
    bus.stat_rx_aligned[1] = 1'b1;
    step();
    bus.restart[1] = 1'b0;
    check("p1_fail_c59", 32'(bus.fail_led[1]), 0);
    check("p1_rx_en_c59", 32'(bus.ctl_rx_enable[1]), 0);
    run_to(60);
    check("p1_busy_c60", 32'(bus.busy_led[1]), 1);
    run_to(63);
    check("p1_up_c63", 32'(bus.link_up[1]), 0);
    run_to(64);
    check("p1_up_c64", 32'(bus.link_up[1]), 1);
    check("all_up_c64", 32'(bus.all_links_up), 1);

    // Port0 aligned pattern 0,1,1,1 repeating: never stable long enough.
    exp_rs0.push_back(83);
    for (int k = 0; k < 26; k++) begin
      bus.stat_rx_aligned[0] = ((k % 4) != 0);
      step();
      if (cyc >= 67) check("p0_never_up", 32'(bus.link_up[0]), 0);
    end
`ifdef CMAC_LINK_SYNC_STATS_EN
    check("ldc0_two", 32'(bus.link_down_cnt[15:0]), 2);
`endif
    check("p0_busy_c90", 32'(bus.busy_led[0]), 1);
    check("rs0_drained", exp_rs0.size(), 0);
    check("rs1_drained", exp_rs1.size(), 0);

    // Asynchronous reset between clock edges.
    #2;
    sys_reset_n = 1'b0;
    #1;
    check("arst_rx_en", 32'(bus.ctl_rx_enable), 0);
    check("arst_rfi", 32'(bus.ctl_tx_send_rfi), 0);
    check("arst_busy", 32'(bus.busy_led), 0);
    check("arst_up", 32'(bus.link_up), 0);
    check("arst_all_up", 32'(bus.all_links_up), 0);
`ifdef CMAC_LINK_SYNC_STATS_EN
    check("arst_ldc", bus.link_down_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmac_link_sync.md
Name: cmac_link_sync

Overview:
- Parametrised successor to the single-port CMAC rx/tx bring-up sync. Manages NUM_PORTS CMAC instances from one monitor clock.
- Per port: enables RX and sends RFI until the port's alignment has been stable for a set time, then enables TX.
- Adds an alignment timeout, forced resync with bounded retries, a terminal FAIL state, and link-down recovery.
- Sits between the CMAC stat/ctl interfaces and the board LEDs / host status registers.

Parameters:
- NUM_PORTS, 2, number of CMAC ports managed (1..4).
- STABLE_CYCLES, 1024, consecutive synchronised aligned samples required to declare link up (>=1).
- ALIGN_TIMEOUT, 2**20, cycles in WAIT_ALIGN before a resync is forced (> STABLE_CYCLES).
- MAX_RETRIES, 7, forced resyncs allowed before FAIL (0..255).

Ports:
- gen_mon_clk  in  1  monitor/control clock, single clock domain.
- sys_reset_n  in  1  asynchronous active-low reset.
- restart  in  NUM_PORTS  per-port restart pulse.
- stat_rx_aligned  in  NUM_PORTS  CMAC RX aligned, asynchronous to gen_mon_clk.
- ctl_rx_enable  out  NUM_PORTS  CMAC RX enable.
- ctl_rx_force_resync  out  NUM_PORTS  one-cycle resync pulse.
- ctl_tx_enable  out  NUM_PORTS  CMAC TX enable.
- ctl_tx_send_rfi  out  NUM_PORTS  send remote fault indication.
- ctl_tx_send_idle  out  NUM_PORTS  always 0 (reserved).
- link_up  out  NUM_PORTS  port in LINK_UP.
- busy_led  out  NUM_PORTS  port in WAIT_ALIGN or RESYNC.
- fail_led  out  NUM_PORTS  port in FAIL.
- all_links_up  out  1  AND of link_up.
- link_down_cnt  out  NUM_PORTS*16  per-port saturating link-loss counters; present only with the optional feature.

Behaviour:
- Reset (sys_reset_n=0, asynchronous): all outputs 0, every FSM in IDLE, all counters 0.
- stat_rx_aligned passes through a 2-flop synchroniser per port (aln_s). Its effect on the FSM is visible 2 cycles after the input changes.
- Per-port FSM states: IDLE, WAIT_ALIGN, RESYNC, LINK_UP, FAIL. All outputs are registered and decoded from the next state, so they change on the cycle of the transition.
- IDLE:
  - All ctl outputs 0.
  - Unconditionally moves to WAIT_ALIGN on the next cycle.
- WAIT_ALIGN:
  - Outputs: ctl_rx_enable=1, ctl_tx_send_rfi=1, ctl_tx_enable=0.
  - stab_cnt increments while aln_s=1 and clears when aln_s=0.
  - tmo_cnt increments every cycle.
  - When stab_cnt reaches STABLE_CYCLES-1 with aln_s=1: go to LINK_UP and clear retry_cnt.
  - Otherwise, when tmo_cnt reaches ALIGN_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL; else go to RESYNC and increment retry_cnt.
  - If stability completes on the same cycle as the timeout, stability wins.
- RESYNC:
  - Lasts exactly 1 cycle with ctl_rx_force_resync=1 and ctl_rx_enable=1.
  - Returns to WAIT_ALIGN with stab_cnt and tmo_cnt cleared.
- LINK_UP:
  - Outputs: ctl_rx_enable=1, ctl_tx_enable=1, ctl_tx_send_rfi=0, link_up=1.
  - aln_s=0 moves to WAIT_ALIGN with counters cleared. This is a link-down event.
- FAIL:
  - Outputs: ctl_rx_enable=0, ctl_tx_enable=0, fail_led=1.
  - Held until restart.
- restart[i]:
  - Highest priority in every state. Forces IDLE next cycle and clears stab_cnt, tmo_cnt and retry_cnt.
  - A restart held high keeps the port in IDLE.
- Ports are fully independent; there is no cross-port interaction except all_links_up.
- Counter widths: $clog2 of the respective limit, plus 1. Counters do not wrap, because a state transition always clears them first.

Optional Feature:
- Macro: CMAC_LINK_SYNC_STATS_EN.
- Defined:
  - link_down_cnt port exists.
  - Each 16-bit field increments on every LINK_UP->WAIT_ALIGN transition and saturates at 16'hFFFF.
  - Fields are cleared only by reset; restart does not clear them.
- Undefined: the port and counters are absent; FSM behaviour is identical.

Decomposition:
- Package cmac_link_sync_pkg holds:
  - link_state_t enum (IDLE, WAIT_ALIGN, RESYNC, LINK_UP, FAIL).
  - LINK_DOWN_CNT_W=16.
  - The synchroniser depth constant SYNC_STAGES=2.
- Sub-module cmac_link_sync_port contains one synchroniser, the FSM and its counters. The top instantiates it NUM_PORTS times in a generate loop and forms all_links_up.

Test Plan:
Bench parameters: NUM_PORTS=2, STABLE_CYCLES=4, ALIGN_TIMEOUT=16, MAX_RETRIES=2.
- Reset release, port0 aligned held high → ctl_rx_enable0=1 one cycle after IDLE; link_up0=1 and ctl_tx_enable0=1 by cycle 1+2+4; ctl_tx_send_rfi0=0 at the same time.
- Port1 aligned never high → force_resync1 pulses at cycles 17 and 34 (1-cycle pulses); fail_led1=1 at cycle 51; all_links_up stays 0.
- Port0 aligned toggles 1,1,1,0 repeatedly → never reaches LINK_UP; force_resync0 asserts at the timeout.
- Port0 in LINK_UP, aligned drops for 1 cycle → link_up0=0 two cycles later; ctl_tx_send_rfi0=1; link_up0 returns after 4 stable cycles; link_down_cnt[15:0]=1 with CMAC_LINK_SYNC_STATS_EN.
- Port1 in FAIL, restart1 pulsed → IDLE, then WAIT_ALIGN with retry_cnt=0; aligned asserted → link_up1=1; all_links_up=1 when port0 is also up.
- sys_reset_n asserted mid-WAIT_ALIGN → all outputs 0 immediately, without waiting for a clock edge.
